// File: rtl/win_banner_ctrl.sv
// WIN banner animation controller.
// Turns the scan position into a one-clk frame tick at the start of vertical
// blanking. Once the game is won, it drops the banner from the top of the
// screen to TARGET_Y, then bounces it horizontally between the screen edges
// while it blinks. Every position and enable update happens on a frame tick,
// or on clear/reset, so the renderer sees stable values for the whole of
// active video.
module win_banner_ctrl #(
  parameter int SCALE        = 1,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int STEP         = 2,
  parameter int TARGET_Y     = 236,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] Q_X,
  input  logic [9:0] Q_Y,
  input  logic       win_i,
  input  logic       clear_i,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       banner_en,
  output logic       frame_tick
);

  // Horizontal travel limit and the centred start column.
  localparam int X_MAX_I = H_ACTIVE - 24 * SCALE;
  localparam int X_CTR_I = X_MAX_I / 2;

  localparam logic [9:0]  X_MAX10  = 10'(X_MAX_I);
  localparam logic [9:0]  X_CTR10  = 10'(X_CTR_I);
  localparam logic [10:0] X_MAX11  = 11'(X_MAX_I);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [9:0]  TGT10    = 10'(TARGET_Y);
  localparam logic [10:0] TGT11    = 11'(TARGET_Y);

  // The blink counter must be able to hold BLINK_FRAMES-1.
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DROP   = 2'd1,
    BOUNCE = 2'd2
  } state_t;

  state_t           state;
  logic             dir_left;
  logic [CNT_W-1:0] blink_cnt;
  logic             vb_cond;
  logic             vb_prev;

  // Start of vertical blanking. This can stay true for several clks when the
  // pixel clock is slower than clk, so the tick is taken on its rising edge.
  assign vb_cond = (Q_Y == 10'(V_ACTIVE)) && (Q_X == 10'd0);

  // Next-step values are formed at 11 bits, so pos + STEP cannot wrap.
  logic [10:0] y_next;
  logic [10:0] x_up;
  logic [9:0]  x_dn;
  assign y_next = {1'b0, pos_y} + STEP11;
  assign x_up   = {1'b0, pos_x} + STEP11;
  assign x_dn   = pos_x - STEP10;

  // Registered frame tick: one clk per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vb_prev    <= vb_cond;
      frame_tick <= vb_cond && !vb_prev;
    end
  end

  // Animation FSM. Clear takes priority over a tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state     <= IDLE;
      pos_x     <= X_CTR10;
      pos_y     <= 10'd0;
      banner_en <= 1'b0;
      dir_left  <= 1'b0;
      blink_cnt <= '0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          // win_i only counts on a tick.
          if (win_i) begin
            state     <= DROP;
            banner_en <= 1'b1;
          end
        end
        DROP: begin
          if (y_next >= TGT11) begin
            pos_y     <= TGT10;
            state     <= BOUNCE;
            banner_en <= 1'b1;
            blink_cnt <= '0;
          end else begin
            pos_y <= y_next[9:0];
          end
        end
        BOUNCE: begin
          pos_y <= TGT10;
          // When the banner reaches an edge it is clamped and turned around
          // in the same update.
          if (!dir_left) begin
            if (x_up >= X_MAX11) begin
              pos_x    <= X_MAX10;
              dir_left <= 1'b1;
            end else begin
              pos_x <= x_up[9:0];
            end
          end else begin
            if (pos_x <= STEP10) begin
              pos_x    <= 10'd0;
              dir_left <= 1'b0;
            end else begin
              pos_x <= x_dn;
            end
          end
          // Blink: toggle the enable every BLINK_FRAMES ticks.
          if (blink_cnt == BLINK_LAST) begin
            banner_en <= !banner_en;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pos_x     <= X_CTR10;
          pos_y     <= 10'd0;
          banner_en <= 1'b0;
          dir_left  <= 1'b0;
          blink_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Bench for win_banner_ctrl. A compressed scan gives each frame 8 clks, and
// the blanking condition is held for 1-3 clks of each frame. The reference
// model tracks only the phase and how many ticks have passed in it, and it
// derives the expected positions and the blink from those tick counts.
module tb_win_banner_ctrl;
  localparam int X_MAX = 616;
  localparam int X_CTR = 308;
  localparam int STEP  = 2;
  localparam int TGT   = 236;
  localparam int BLINK = 30;
  localparam int VA    = 480;

  logic       clk = 1'b0;
  logic       rst, win_i, clear_i;
  logic [9:0] Q_X, Q_Y, pos_x, pos_y;
  logic       banner_en, frame_tick;

  always #5 clk = ~clk;

  win_banner_ctrl dut (
    .clk(clk), .rst(rst), .Q_X(Q_X), .Q_Y(Q_Y), .win_i(win_i),
    .clear_i(clear_i), .pos_x(pos_x), .pos_y(pos_y),
    .banner_en(banner_en), .frame_tick(frame_tick)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: ms 0=idle 1=drop 2=bounce; md/mb = ticks spent in drop/bounce.
  int ms, md, mb;
  bit mtick, mprev;
  int fpos = 0;
  int clen = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bounce path unfolded into a straight line, then folded back as a triangle wave.
  function automatic int ex_x();
    int u, r;
    if (ms != 2) return X_CTR;
    u = X_CTR + STEP * mb;
    r = u % (2 * X_MAX);
    return (r <= X_MAX) ? r : (2 * X_MAX - r);
  endfunction

  function automatic int ex_y();
    if (ms == 0) return 0;
    if (ms == 1) return STEP * md;
    return TGT;
  endfunction

  function automatic int ex_en();
    if (ms == 0) return 0;
    if (ms == 1) return 1;
    return (((mb / BLINK) % 2) == 0) ? 1 : 0;
  endfunction

  // Apply one clk of stimulus, advance the model, then check after the edge.
  task automatic cyc(input bit r, input bit c, input bit w);
    bit cond, t;
    if (fpos < clen) begin
      Q_Y = 10'(VA); Q_X = 10'd0;
    end else begin
      case ($urandom_range(0, 3))
        0: begin Q_Y = 10'(VA); Q_X = 10'($urandom_range(1, 1023)); end
        1: begin Q_Y = 10'($urandom_range(0, VA - 1)); Q_X = 10'd0; end
        default: begin Q_Y = 10'($urandom); Q_X = 10'($urandom); end
      endcase
    end
    fpos = (fpos == 7) ? 0 : fpos + 1;
    if (fpos == 0) clen = $urandom_range(1, 3);
    rst = r; clear_i = c; win_i = w;
    cond = (Q_Y == 10'(VA)) && (Q_X == 10'd0);
    if (r) begin
      ms = 0; md = 0; mb = 0; mtick = 0; mprev = 0;
    end else begin
      t     = mtick;
      mtick = cond && !mprev;
      mprev = cond;
      if (c) begin
        ms = 0; md = 0; mb = 0;
      end else if (t) begin
        case (ms)
          0: if (w) begin ms = 1; md = 0; end
          1: begin
            md++;
            if (STEP * md >= TGT) begin ms = 2; mb = 0; end
          end
          default: mb++;
        endcase
      end
    end
    @(posedge clk);
    #1;
    chk("frame_tick", 32'(frame_tick), 32'(mtick));
    chk("pos_x",      32'(pos_x),      32'(ex_x()));
    chk("pos_y",      32'(pos_y),      32'(ex_y()));
    chk("banner_en",  32'(banner_en),  32'(ex_en()));
  endtask

  initial begin
    int k;
    Q_X = 10'd0; Q_Y = 10'd0; rst = 1'b1; clear_i = 1'b0; win_i = 1'b0;
    ms = 0; md = 0; mb = 0; mtick = 0; mprev = 0;

    // Reset, including with win and clear asserted.
    cyc(1, 0, 0);
    cyc(1, 1, 1);

    // Full drop followed by a complete bounce round trip. Once the banner has
    // left idle, win_i is randomised, because dropping it must have no effect.
    repeat (700 * 8) cyc(0, 0, (ms == 0) ? 1'b1 : 1'($urandom_range(0, 1)));

    // Clear arriving on the same clk as a tick during bounce.
    k = 0;
    while (!(ms == 2 && mtick) && k < 200) begin cyc(0, 0, 1); k++; end
    chk("bounce_tick_wait", 32'(k < 200), 32'd1);
    cyc(0, 1, 1);
    repeat (5) cyc(0, 0, 0);

    // Clear and win together on an idle tick: the FSM stays in idle.
    k = 0;
    while (!mtick && k < 200) begin cyc(0, 0, 0); k++; end
    chk("idle_tick_wait", 32'(k < 200), 32'd1);
    cyc(0, 1, 1);
    repeat (3) cyc(0, 0, 0);

    // Reset in mid-drop at pos_y = 100, then stay idle while win_i is low.
    k = 0;
    while (!(ms == 1 && md == 50) && k < 2000) begin cyc(0, 0, 1); k++; end
    chk("mid_drop_wait", 32'(k < 2000), 32'd1);
    cyc(1, 0, 1);
    repeat (60 * 8) cyc(0, 0, 0);

    // Randomised mix of win, clear and occasional reset.
    repeat (12000)
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/win_banner_ctrl.md
WIN_BANNER_CTRL -- requirements
Module: win_banner_ctrl

Interface
REQ-001 SHALL have parameter SCALE, default 1: banner glyph scale; banner is 24*SCALE x 8*SCALE px.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible width in px.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible height in px.
REQ-004 SHALL have parameter STEP, default 2: px moved per frame.
REQ-005 SHALL have parameter TARGET_Y, default 236: final drop row.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30: frames per blink half-period.
REQ-007 SHALL have port clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port Q_X  input  10  current scan column from the VGA timing block.
REQ-010 SHALL have port Q_Y  input  10  current scan row from the VGA timing block.
REQ-011 SHALL have port win_i  input  1  game-won level.
REQ-012 SHALL have port clear_i  input  1  return-to-idle request, single-cycle pulse or level.
REQ-013 SHALL have port pos_x  output  10  banner left column, fed to the WIN glyph renderer.
REQ-014 SHALL have port pos_y  output  10  banner top row, fed to the WIN glyph renderer.
REQ-015 SHALL have port banner_en  output  1  gate ANDed with the renderer's visible output.
REQ-016 SHALL have port frame_tick  output  1  one-clk pulse at start of vertical blanking.

Function
REQ-017 Derived constants SHALL be X_MAX = H_ACTIVE - 24*SCALE and X_CTR = X_MAX/2 (truncating); with defaults, X_MAX = 616 and X_CTR = 308.
REQ-018 frame_tick SHALL be registered; it SHALL pulse high for exactly one clk when the condition (Q_Y == V_ACTIVE && Q_X == 0) is true this cycle and was false the previous cycle, so it fires once per frame regardless of pixel-clock/clk ratio.
REQ-019 The FSM SHALL have states IDLE, DROP and BOUNCE, and SHALL change state only on frame_tick (except on clear_i or rst).
REQ-020 In IDLE: pos_x = X_CTR, pos_y = 0, banner_en = 0, dir = right, blink counter = 0.
REQ-021 IDLE -> DROP SHALL occur on frame_tick with win_i = 1; win_i sampled on any other cycle SHALL be ignored.
REQ-022 In DROP: banner_en = 1; on each frame_tick pos_y += STEP; if pos_y + STEP >= TARGET_Y, pos_y = TARGET_Y and the FSM enters BOUNCE.
REQ-023 In BOUNCE: pos_y SHALL hold TARGET_Y; on each frame_tick pos_x moves STEP in dir.
REQ-024 BOUNCE right edge: if pos_x + STEP >= X_MAX, pos_x = X_MAX and dir flips to left in the same update.
REQ-025 BOUNCE left edge: if pos_x <= STEP, pos_x = 0 and dir flips to right in the same update.
REQ-026 BOUNCE blink: a counter SHALL count frame_ticks; on reaching BLINK_FRAMES, banner_en toggles and the counter clears.
REQ-027 Entry to BOUNCE SHALL set banner_en = 1 and clear the counter.
REQ-028 Edge comparisons SHALL be done at 11 bits so pos + STEP never wraps; pos_x SHALL be in [0, X_MAX] and pos_y in [0, TARGET_Y] at all times.
REQ-029 Deasserting win_i after leaving IDLE SHALL have no effect; only clear_i or rst ends the animation.
REQ-030 clear_i = 1 in any state SHALL force IDLE values (REQ-020) on the next clk edge, with priority over a simultaneous frame_tick.
REQ-031 If clear_i and win_i are both high on a frame_tick, the FSM SHALL end in IDLE; DROP begins on a later tick where clear_i = 0.
REQ-032 Outputs SHALL be registered, and updates SHALL occur only on frame_tick cycles or on clear/reset, so positions are stable throughout active video.

Reset
REQ-033 On rst = 1 at a clk edge: state = IDLE, pos_x = X_CTR (308), pos_y = 0, banner_en = 0, frame_tick = 0, dir = right, blink counter = 0, and the previous-condition flag = 0.
REQ-034 rst SHALL take priority over clear_i, win_i and frame_tick, and asserting rst mid-DROP or mid-BOUNCE SHALL yield the REQ-033 values on the next edge.

Verification
REQ-035 Free-running 640x480 scan at 2 clk/pixel -> frame_tick is exactly one clk wide, once per frame, at Q_Y = 480, Q_X = 0.
REQ-036 win_i = 1 held from IDLE -> DROP entered on the next tick; pos_y = 2, 4, ... 234, then 236 on tick 118 with state BOUNCE; pos_x = 308 throughout.
REQ-037 BOUNCE from pos_x = 308, dir right -> pos_x = 616 after 154 ticks with dir left; pos_x = 0 after 308 more ticks with dir right.
REQ-038 Blink in BOUNCE -> banner_en = 1 for 30 ticks, 0 for 30 ticks, repeating.
REQ-039 clear_i pulsed on the same clk as frame_tick during BOUNCE -> next cycle pos_x = 308, pos_y = 0, banner_en = 0, state IDLE.
REQ-040 rst asserted mid-DROP (pos_y = 100) -> REQ-033 values on the next edge; win_i = 0 afterwards -> stays in IDLE indefinitely.
